// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO controller, register file and drain stage.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH  = 8;
  localparam int unsigned FIFO_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/fifo_drain.sv
// Drain stage: pops the FIFO into a 2-entry skid buffer and presents words on a
// registered valid/ready stream while counting accepted words.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int unsigned COUNT_WIDTH = FIFO_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   empty,
  input  logic [DATA_WIDTH-1:0]  r_data,
  input  logic                   hold,
  output logic                   rd,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] words_out
);

  drain_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0]  head_q, head_d;
  logic [DATA_WIDTH-1:0]  tail_q, tail_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   drn;

  // Pop decision looks only at local occupancy, never at out_ready.
  assign rd  = ~reset & ~empty & ~hold & (state_q != S_TWO);
  assign drn = (state_q != S_EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drn) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
    unique case (state_q)
      S_EMPTY: begin
        if (rd) begin
          head_d  = r_data;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (rd && !drn) begin
          tail_d  = r_data;
          state_d = S_TWO;
        end else if (!rd && drn) begin
          state_d = S_EMPTY;
        end else if (rd && drn) begin
          head_d  = r_data;
        end
      end
      S_TWO: begin
        if (drn) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = head_q;
  assign words_out = count_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Randomized and directed checks of fifo_drain against a queue-based model of
// the upstream FIFO and the 2-word output buffer.
module tb_fifo_drain;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] r_data = '0;
  logic       hold = 1'b0;
  logic       out_ready = 1'b0;

  logic        rd, out_valid;
  logic [7:0]  out_data;
  logic [15:0] words_out;
  logic        rd4, out_valid4;
  logic [7:0]  out_data4;
  logic [3:0]  words_out4;

  fifo_drain #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .empty(empty), .r_data(r_data), .hold(hold),
    .rd(rd), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .words_out(words_out)
  );

  fifo_drain #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) u_dut_w4 (
    .clk(clk), .reset(reset), .empty(empty), .r_data(r_data), .hold(hold),
    .rd(rd4), .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .words_out(words_out4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] buf_q[$];
  logic [7:0] seen_q[$];
  int         cnt = 0;
  int         rd_seen = 0;
  logic       last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic hld, input logic rdy);
    logic exp_rd, exp_valid, drn;
    @(negedge clk);
    reset     = rst;
    hold      = hld;
    out_ready = rdy;
    empty     = (fifo_q.size() == 0);
    r_data    = empty ? 8'($urandom) : fifo_q[0];
    #1;
    exp_rd    = !rst && !empty && !hld && (buf_q.size() < 2);
    exp_valid = (buf_q.size() != 0);
    check_eq("rd", 32'(rd), 32'(exp_rd));
    check_eq("rd_w4", 32'(rd4), 32'(exp_rd));
    check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
    check_eq("out_valid_w4", 32'(out_valid4), 32'(exp_valid));
    if (exp_valid) begin
      check_eq("out_data", 32'(out_data), 32'(buf_q[0]));
      check_eq("out_data_w4", 32'(out_data4), 32'(buf_q[0]));
    end
    check_eq("words_out", 32'(words_out), cnt & 32'hFFFF);
    check_eq("words_out_w4", 32'(words_out4), cnt & 32'hF);
    last_rd = rd;
    if (rd) rd_seen++;
    if (out_valid && rdy) seen_q.push_back(out_data);
    drn = exp_valid && rdy;
    @(posedge clk);
    if (rst) begin
      buf_q.delete();
      fifo_q.delete();
      cnt = 0;
    end else begin
      if (drn) begin
        void'(buf_q.pop_front());
        cnt++;
      end
      if (exp_rd) buf_q.push_back(fifo_q.pop_front());
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    seen_q.delete();
    rd_seen = 0;
  endtask

  initial begin
    int prev;
    logic [7:0] exp3[3];
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;

    // Reset then idle with an empty FIFO.
    do_reset();
    check_eq("rst_out_data", 32'(out_data), 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    check_eq("idle_rd_count", 32'(rd_seen), 32'd0);
    check_eq("idle_words", 32'(words_out), 32'd0);

    // Preload with ready high: three back-to-back pops, in-order delivery.
    do_reset();
    fifo_q = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    check_eq("stream_rd_count", 32'(rd_seen), 32'd3);
    check_eq("stream_seen_n", 32'(seen_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < seen_q.size(); i++) check_eq("stream_word", 32'(seen_q[i]), 32'(exp3[i]));
    check_eq("stream_words", 32'(words_out), 32'd3);

    // Preload with ready low: only two pops, head held, then ordered drain.
    do_reset();
    fifo_q = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    check_eq("bp_rd_count", 32'(rd_seen), 32'd2);
    check_eq("bp_head", 32'(out_data), 32'h11);
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    check_eq("bp_seen_n", 32'(seen_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < seen_q.size(); i++) check_eq("bp_word", 32'(seen_q[i]), 32'(exp3[i]));

    // Hold after the first pop: popping freezes, buffered word drains, release resumes.
    do_reset();
    fifo_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    step(1'b0, 1'b0, 1'b1);
    check_eq("hold_first_rd", 32'(last_rd), 32'd1);
    rd_seen = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    check_eq("hold_rd_count", 32'(rd_seen), 32'd0);
    check_eq("hold_drained", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check_eq("hold_release_rd", 32'(last_rd), 32'd1);

    // Reset while holding two words.
    do_reset();
    fifo_q = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    check_eq("two_third_rd", 32'(last_rd), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("rst_mid_rd", 32'(last_rd), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_words", 32'(words_out), 32'd0);

    // 4-bit counter wrap over 17 deliveries.
    do_reset();
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'(i + 1));
    for (int i = 0; i < 40 && seen_q.size() < 17; i++) begin
      prev = seen_q.size();
      step(1'b0, 1'b0, 1'b1);
      #1;
      if (seen_q.size() != prev) begin
        if (seen_q.size() == 15) check_eq("wrap_15", 32'(words_out4), 32'd15);
        if (seen_q.size() == 16) check_eq("wrap_16", 32'(words_out4), 32'd0);
        if (seen_q.size() == 17) check_eq("wrap_17", 32'(words_out4), 32'd1);
      end
    end
    check_eq("wrap_seen_n", 32'(seen_q.size()), 32'd17);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (fifo_q.size() < 8 && $urandom_range(1, 0) == 1) fifo_q.push_back(8'($urandom));
      step($urandom_range(99, 0) == 0, $urandom_range(7, 0) == 0, $urandom_range(2, 0) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
